// File: rtl/pc_fetch.sv
// Program-counter and instruction-fetch stage of the multicycle RV32 core.
// Fetches one instruction per request/grant/response handshake and advances the PC on update.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_step,
  input  logic        pc_abs_valid,
  input  logic [31:0] pc_abs,
  input  logic        update,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] next_pc;

  // jalr targets have bit 0 cleared; the relative add wraps modulo 2^32
  assign next_pc = pc_abs_valid ? {pc_abs[31:1], 1'b0} : (pc_q + pc_step);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instret_d     = instret_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = misalign_q;
    unique case (state_q)
      S_REQ: begin
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (update) begin
          pc_d          = next_pc;
          instret_d     = instret_q + 32'd1;
          instr_valid_d = 1'b0;
          if (next_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = S_ERR;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_ERR: begin
        instr_valid_d = 1'b0;
        misalign_d    = 1'b1;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instret_q     <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instret_q     <= instret_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem_req     = (state_q == S_REQ);
  assign imem_addr    = pc_q;
  assign instr_valid  = instr_valid_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign pc           = pc_q;
  assign instret      = instret_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch: fetch loop, PC arithmetic, misalignment and reset.
module tb_pc_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_step;
  logic        pc_abs_valid;
  logic [31:0] pc_abs;
  logic        update;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        misalign_err;

  int compared;
  int mismatched;

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_step      (pc_step),
    .pc_abs_valid (pc_abs_valid),
    .pc_abs       (pc_abs),
    .update       (update),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .pc           (pc),
    .instret      (instret),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // From REQ: one granted request, response the next cycle, ends in HOLD.
  task automatic fetch(input logic [31:0] word);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    tick();
    imem_rvalid = 1'b0;
  endtask

  task automatic do_update(input logic [31:0] step, input logic absv, input logic [31:0] abs);
    pc_step      = step;
    pc_abs_valid = absv;
    pc_abs       = abs;
    update       = 1'b1;
    tick();
    update       = 1'b0;
    pc_abs_valid = 1'b0;
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst          = 1'b1;
    pc_step      = '0;
    pc_abs_valid = 1'b0;
    pc_abs       = '0;
    update       = 1'b0;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;

    tick();
    tick();
    rst = 1'b0;
    check("rst_pc", pc, 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_ivalid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_misalign", {31'b0, misalign_err}, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h1);
    check("rst_addr", imem_addr, 32'h0);

    // No grant and a stray rvalid: request held, rvalid ignored
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    tick();
    imem_rvalid = 1'b0;
    check("req_hold", {31'b0, imem_req}, 32'h1);
    check("req_addr_stable", imem_addr, 32'h0);
    check("req_rvalid_ignored", {31'b0, instr_valid}, 32'h0);

    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("wait_req_low", {31'b0, imem_req}, 32'h0);
    check("wait_ivalid", {31'b0, instr_valid}, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0;
    check("first_ivalid", {31'b0, instr_valid}, 32'h1);
    check("first_instr", instr, 32'h0050_0093);
    check("first_instr_pc", instr_pc, 32'h0);

    do_update(32'h10, 1'b0, 32'h0);
    check("jump_to_10", pc, 32'h10);
    check("instret_1", instret, 32'h1);

    fetch(32'h1111_1111);
    check("hold_instr_pc_10", instr_pc, 32'h10);
    do_update(32'h4, 1'b0, 32'h0);
    check("seq_addr", imem_addr, 32'h14);
    check("seq_req", {31'b0, imem_req}, 32'h1);
    check("seq_instret", instret, 32'h2);
    check("seq_ivalid_clr", {31'b0, instr_valid}, 32'h0);

    // update pulsed while waiting for the response must be ignored
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    do_update(32'h8, 1'b0, 32'h0);
    check("ign_pc", pc, 32'h14);
    check("ign_instret", instret, 32'h2);
    check("ign_req", {31'b0, imem_req}, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h2222_2222;
    tick();
    imem_rvalid = 1'b0;
    check("ign_then_hold", {31'b0, instr_valid}, 32'h1);
    do_update(32'hC, 1'b0, 32'h0);
    check("pc_20", pc, 32'h20);

    fetch(32'h3333_3333);
    do_update(32'hFFFF_FFF8, 1'b0, 32'h0);
    check("back_branch", pc, 32'h18);
    check("back_instret", instret, 32'h4);

    fetch(32'h4444_4444);
    do_update(32'h0, 1'b1, 32'hFFFF_FFFD);
    check("abs_top", pc, 32'hFFFF_FFFC);
    check("abs_top_noerr", {31'b0, misalign_err}, 32'h0);

    fetch(32'h5555_5555);
    do_update(32'h4, 1'b0, 32'h0);
    check("wrap_pc", pc, 32'h0);
    check("wrap_noerr", {31'b0, misalign_err}, 32'h0);
    check("wrap_req", {31'b0, imem_req}, 32'h1);
    check("wrap_instret", instret, 32'h6);

    fetch(32'h6666_6666);
    do_update(32'h40, 1'b1, 32'h201);
    check("abs_pc", pc, 32'h200);
    check("abs_req", {31'b0, imem_req}, 32'h1);
    check("abs_instret", instret, 32'h7);

    // Reset in WAIT, then a late response that must be dropped
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("rstw_ivalid", {31'b0, instr_valid}, 32'h0);
    check("rstw_instr", instr, 32'h0);
    check("rstw_req", {31'b0, imem_req}, 32'h1);
    check("rstw_addr", imem_addr, 32'h0);
    check("rstw_instret", instret, 32'h0);

    fetch(32'h7777_7777);
    check("rstw_fetch_instr", instr, 32'h7777_7777);
    do_update(32'h6, 1'b0, 32'h0);
    check("mis_pc", pc, 32'h6);
    check("mis_err", {31'b0, misalign_err}, 32'h1);
    check("mis_req", {31'b0, imem_req}, 32'h0);
    check("mis_ivalid", {31'b0, instr_valid}, 32'h0);
    check("mis_instret", instret, 32'h1);

    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    update      = 1'b1;
    pc_step     = 32'h4;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("err_req_low", {31'b0, imem_req}, 32'h0);
    end
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    update      = 1'b0;
    check("err_pc_held", pc, 32'h6);
    check("err_instret_held", instret, 32'h1);
    check("err_sticky", {31'b0, misalign_err}, 32'h1);
    check("err_ivalid", {31'b0, instr_valid}, 32'h0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err_rst_clear", {31'b0, misalign_err}, 32'h0);
    check("err_rst_pc", pc, 32'h0);
    check("err_rst_req", {31'b0, imem_req}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
